// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    KILL
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, req/ack fetch FSM and a one-entry
// valid/ready buffer facing the IF/ID boundary.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_plus4_o,
  input  logic [XLEN-1:0] pc_next_i,
  input  logic            redirect_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            if_ready_i
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_q, req_addr_q, instr_q, bpc_q;
  logic            valid_q;
  logic            req, load, capture;

  // Low address bits of the redirect target are discarded by design.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_next_i[1:0];

  assign pc_plus4_o = pc_q + PC_INCR;
  assign imem_req_o = req && !rst;
  assign if_valid_o = valid_q;
  assign if_instr_o = instr_q;
  assign if_pc_o    = bpc_q;

  always_comb begin
    state_nxt   = state;
    req         = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;
    imem_addr_o = pc_q;
    case (state)
      IDLE: begin
        req = !valid_q || if_ready_i;
        if (req) begin
          if (imem_ack_i) begin
            load = !redirect_i;
          end else begin
            capture   = 1'b1;
            state_nxt = redirect_i ? KILL : WAIT;
          end
        end
      end
      WAIT: begin
        req         = 1'b1;
        imem_addr_o = req_addr_q;
        if (imem_ack_i) begin
          load      = !redirect_i;
          state_nxt = IDLE;
        end else if (redirect_i) begin
          state_nxt = KILL;
        end
      end
      KILL: begin
        // Response belongs to a squashed path; just wait it out.
        req         = 1'b1;
        imem_addr_o = req_addr_q;
        if (imem_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      bpc_q      <= '0;
    end else begin
      state <= state_nxt;
      if (capture) req_addr_q <= pc_q;

      if (redirect_i)  pc_q <= {pc_next_i[XLEN-1:2], 2'b00};
      else if (load)   pc_q <= pc_plus4_o;

      // Redirect flushes even a stalled buffer; a load in a drain cycle replaces it.
      if (redirect_i) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        instr_q <= imem_rdata_i;
        bpc_q   <= imem_addr_o;
      end else if (if_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stage and a variable-latency memory.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_plus4_o, pc_next_i, imem_addr_o, imem_rdata_i, if_instr_o, if_pc_o;
  logic        redirect_i, imem_req_o, imem_ack_i, if_valid_o, if_ready_i;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .pc_plus4_o(pc_plus4_o), .pc_next_i(pc_next_i), .redirect_i(redirect_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
    .if_ready_i(if_ready_i)
  );

  int checks = 0;
  int errors = 0;

  // Model: next PC, one outstanding request (possibly squashed), output buffer.
  logic [31:0] m_pc, m_oaddr, m_bi, m_bp, exp_addr;
  bit          m_out, m_dead, m_bv, exp_req;
  // Memory: per-request count of no-ack cycles.
  int          mem_cnt;
  bit          mem_busy;
  int          lat_force = -1;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_dead = 0; m_bv = 0; m_bi = 0; m_bp = 0;
    m_oaddr = 0; mem_busy = 0; mem_cnt = 0;
  endtask

  // Called at negedge after the caller sets rst/if_ready_i/redirect_i/pc_next_i.
  task automatic drive();
    exp_req  = !rst && (m_out || !m_bv || if_ready_i);
    exp_addr = m_out ? m_oaddr : m_pc;
    #1;
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    if (imem_req_o) begin
      if (!mem_busy) begin
        mem_cnt  = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        mem_busy = 1;
      end
      if (mem_cnt == 0) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = word(imem_addr_o);
      end
    end
    #1;
  endtask

  task automatic tick();
    bit ld;
    if (rst) begin
      model_reset();
    end else begin
      ld = exp_req && imem_ack_i && !redirect_i && !(m_out && m_dead);
      if (exp_req && imem_ack_i) m_out = 0;
      else if (exp_req && !m_out) begin m_out = 1; m_oaddr = m_pc; m_dead = redirect_i; end
      else if (m_out && redirect_i) m_dead = 1;
      if (redirect_i) m_bv = 0;
      else if (ld) begin m_bv = 1; m_bi = imem_rdata_i; m_bp = exp_addr; end
      else if (m_bv && if_ready_i) m_bv = 0;
      if (redirect_i) m_pc = {pc_next_i[31:2], 2'b00};
      else if (ld) m_pc = m_pc + 32'd4;
      if (imem_ack_i) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; if_ready_i = 1; redirect_i = 0; pc_next_i = 0;
    drive(); tick();
    drive();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_valid_o); end
    checks++; if (if_instr_o !== 32'h0 || if_pc_o !== 32'h0) begin errors++; $display("FAIL rst_buf got %h/%h want 0/0", if_instr_o, if_pc_o); end
    checks++; if (pc_plus4_o !== 32'h4) begin errors++; $display("FAIL rst_plus4 got %h want 4", pc_plus4_o); end
    tick();
    rst = 0;
  endtask

  task automatic test_zero_wait();
    lat_force = 0; if_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      drive();
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4*i)) begin errors++; $display("FAIL zw_addr%0d got %b/%h want 1/%h", i, imem_req_o, imem_addr_o, 4*i); end
      if (i > 0) begin
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'(4*(i-1)) || if_instr_o !== word(32'(4*(i-1)))) begin
          errors++; $display("FAIL zw_buf%0d got %b/%h/%h want 1/%h/%h", i, if_valid_o, if_pc_o, if_instr_o, 4*(i-1), word(32'(4*(i-1)))); end
      end
      tick();
    end
  endtask

  task automatic test_latency();
    lat_force = 2; if_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lat_force = 0;
      drive();
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== ((i < 3) ? 32'h10 : 32'h14)) begin errors++; $display("FAIL lat_addr%0d got %b/%h", i, imem_req_o, imem_addr_o); end
      checks++; if (if_valid_o !== (i == 0 || i == 3)) begin errors++; $display("FAIL lat_valid%0d got %b", i, if_valid_o); end
      if (i == 3) begin
        checks++; if (if_pc_o !== 32'h10 || if_instr_o !== word(32'h10)) begin errors++; $display("FAIL lat_buf got %h/%h want 10/%h", if_pc_o, if_instr_o, word(32'h10)); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    if_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      drive();
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b want 0", i, imem_req_o); end
      checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h14 || if_instr_o !== word(32'h14)) begin
        errors++; $display("FAIL stall_buf%0d got %b/%h/%h want 1/14/%h", i, if_valid_o, if_pc_o, if_instr_o, word(32'h14)); end
      tick();
    end
    if_ready_i = 1;
    drive();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h18) begin errors++; $display("FAIL stall_resume got %b/%h want 1/18", imem_req_o, imem_addr_o); end
    tick();
  endtask

  task automatic test_redirect_kill();
    lat_force = 0; drive(); tick();              // fetch 0x1C, pc -> 0x20
    lat_force = 2;
    for (int i = 0; i < 5; i++) begin
      redirect_i = (i == 0); pc_next_i = 32'h200;
      if (i == 3) lat_force = 0;
      drive();
      if (i < 3) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h20) begin errors++; $display("FAIL kill_hold%0d got %b/%h want 1/20", i, imem_req_o, imem_addr_o); end
      end
      if (i > 0) begin
        checks++; if (if_valid_o !== (i == 4)) begin errors++; $display("FAIL kill_valid%0d got %b", i, if_valid_o); end
      end
      if (i == 3) begin
        checks++; if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL kill_target got %h want 200", imem_addr_o); end
      end
      if (i == 4) begin
        checks++; if (if_pc_o !== 32'h200) begin errors++; $display("FAIL kill_buf got %h want 200", if_pc_o); end
      end
      tick();
    end
    redirect_i = 0;
  endtask

  task automatic test_redirect_ack();
    lat_force = 0; redirect_i = 1; pc_next_i = 32'h103;
    drive(); tick();
    redirect_i = 0;
    drive();
    checks++; if (imem_addr_o !== 32'h100 || if_valid_o !== 1'b0) begin errors++; $display("FAIL rack_addr got %h/%b want 100/0", imem_addr_o, if_valid_o); end
    tick();
    drive();
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100) begin errors++; $display("FAIL rack_buf got %b/%h want 1/100", if_valid_o, if_pc_o); end
    tick();
  endtask

  task automatic test_wrap();
    lat_force = 0; redirect_i = 1; pc_next_i = 32'hFFFF_FFFF;
    drive(); tick();
    redirect_i = 0;
    drive();
    checks++; if (pc_plus4_o !== 32'h0 || imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_plus4 got %h/%h want 0/fffffffc", pc_plus4_o, imem_addr_o); end
    tick();
    drive();
    checks++; if (imem_addr_o !== 32'h0 || if_pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h4) begin
      errors++; $display("FAIL wrap_next got %h/%h/%h want 0/fffffffc/4", imem_addr_o, if_pc_o, pc_plus4_o); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    lat_force = 3;
    drive(); tick();
    rst = 1; drive(); tick();
    rst = 0; lat_force = 0;
    drive();
    checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rstw_restart got %b/%b/%h want 0/1/0", if_valid_o, imem_req_o, imem_addr_o); end
    tick();
    drive();
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) begin errors++; $display("FAIL rstw_buf got %b/%h want 1/0", if_valid_o, if_pc_o); end
    tick();
  endtask

  task automatic test_random();
    lat_force = -1;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      if_ready_i = ($urandom_range(0, 9) < 7);
      redirect_i = ($urandom_range(0, 99) < 15);
      pc_next_i  = $urandom;
      drive();
      checks++; if (imem_req_o !== exp_req) begin errors++; $display("FAIL rnd_req c%0d got %b want %b", i, imem_req_o, exp_req); end
      if (exp_req) begin
        checks++; if (imem_addr_o !== exp_addr) begin errors++; $display("FAIL rnd_addr c%0d got %h want %h", i, imem_addr_o, exp_addr); end
      end
      checks++; if (if_valid_o !== m_bv) begin errors++; $display("FAIL rnd_valid c%0d got %b want %b", i, if_valid_o, m_bv); end
      if (m_bv) begin
        checks++; if (if_pc_o !== m_bp || if_instr_o !== m_bi) begin errors++; $display("FAIL rnd_buf c%0d got %h/%h want %h/%h", i, if_pc_o, if_instr_o, m_bp, m_bi); end
      end
      checks++; if (pc_plus4_o !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4 c%0d got %h want %h", i, pc_plus4_o, m_pc + 32'd4); end
      tick();
    end
    rst = 0; redirect_i = 0;
  endtask

  initial begin
    rst = 1; if_ready_i = 1; redirect_i = 0; pc_next_i = 0;
    imem_ack_i = 0; imem_rdata_i = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_kill();
    test_redirect_ack();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RV32I core. Holds the program counter, issues req/ack fetches to instruction memory, and presents fetched instructions to the IF/ID boundary through a one-entry valid/ready output buffer. Sits directly upstream of the PC-select 2:1 mux:
- it drives that mux's sequential input with `pc_plus4_o`;
- it takes the mux output back on `pc_next_i` whenever `redirect_i` (the mux select) is high.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_plus4_o  out  32  pc_q + 4, combinational, wraps modulo 2^32; feeds the PC-select mux sequential input.
- pc_next_i  in  32  PC-select mux output; loaded into pc_q when redirect_i=1; bits [1:0] ignored (forced 00).
- redirect_i  in  1  taken branch/jump from EX; same signal as the PC-select mux select.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; stable while a request is outstanding.
- imem_ack_i  in  1  fetch response valid; may arrive in the same cycle as the request (0-wait) or any later cycle.
- imem_rdata_i  in  32  instruction word; valid when imem_ack_i=1.
- if_valid_o  out  1  output buffer holds an instruction.
- if_instr_o  out  32  buffered instruction.
- if_pc_o  out  32  PC of the buffered instruction.
- if_ready_i  in  1  decode accepts the buffer this cycle; low while decode is stalled.

## Operation
- Registers:
  - pc_q: next fetch PC.
  - req_addr_q: address of the outstanding request.
  - state: IDLE / WAIT / KILL.
  - Output buffer: valid_q, instr_q, bpc_q.
- Handshake: once imem_req_o is high without ack, it stays high and imem_addr_o stays constant until imem_ack_i. Exactly one ack per request; at most one request outstanding.
- IDLE:
  - imem_req_o = !valid_q || if_ready_i.
  - imem_addr_o = pc_q.
  - req && ack && !redirect_i: load buffer (instr_q=rdata, bpc_q=pc_q, valid_q=1), pc_q += 4, stay IDLE.
  - req && ack && redirect_i: discard data, stay IDLE.
  - req && !ack: req_addr_q <= pc_q; next state is KILL if redirect_i, else WAIT.
- WAIT:
  - imem_req_o=1, imem_addr_o=req_addr_q.
  - The buffer is empty here by construction.
  - ack && !redirect_i: load buffer, pc_q += 4, go to IDLE.
  - ack && redirect_i: discard, go to IDLE.
  - !ack && redirect_i: go to KILL.
- KILL:
  - imem_req_o=1, imem_addr_o=req_addr_q.
  - On ack: discard, go to IDLE.
  - Further redirects only update pc_q.
- Redirect, in every state (highest priority):
  - pc_q <= {pc_next_i[31:2],2'b00};
  - valid_q <= 0 (even if if_ready_i=0);
  - no instruction from before the redirect reaches decode afterward.
- Buffer drain: valid_q && if_ready_i && no load this cycle → valid_q <= 0. Drain and load in the same cycle → buffer replaced, valid stays 1.
- Reset: state=IDLE, pc_q=RESET_PC, valid_q=0. Instruction memory shares rst, so no stale ack follows reset. Reset mid-request abandons it.

## Timing
- Outputs during the rst=1 cycle and after it:
  - imem_req_o=0 while rst=1.
  - if_valid_o=0, if_instr_o=0, if_pc_o=0.
  - pc_plus4_o=RESET_PC+4.
  - First request (addr RESET_PC) in the first cycle with rst=0.
- Latency: instruction visible on if_instr_o the cycle after its ack.
- Throughput: 1 instruction/cycle with 0-wait memory and if_ready_i=1; with N-cycle ack latency, 1 per N+1 cycles.
- Redirect penalty (0-wait): redirect in cycle t, fetch of the target in t+1, valid at decode in t+2.
- PC wrap: 0xFFFF_FFFC + 4 = 0x0000_0000, no flag.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, KILL};
  - XLEN=32;
  - PC_INCR=32'd4.
- No sub-module. The output buffer and FSM are inline; the 2:1 PC select stays external.

## Test plan
- Reset, 0-wait memory, if_ready_i=1 → imem_addr_o 0x0,0x4,0x8 on consecutive cycles; if_pc_o 0x0,0x4 with matching rdata one cycle after each ack.
- 3-cycle ack latency at 0x10 → imem_req_o held 3 cycles with addr 0x10 stable; if_pc_o=0x10 one cycle after ack; next request at 0x14.
- if_ready_i low 4 cycles with buffer full → imem_req_o=0, if_instr_o/if_pc_o stable; resumes same cycle if_ready_i rises.
- Redirect to 0x200 while request 0x20 outstanding (ack 2 cycles later) → KILL state, 0x20 data never valid, if_valid_o=0, next request at 0x200.
- Redirect to 0x103 with ack in same cycle → data discarded, next request addr 0x100.
- pc_q=0xFFFF_FFFC → pc_plus4_o=0x0; fetch after wraps to 0x0; rst asserted mid-WAIT → next cycle if_valid_o=0, request restarts at RESET_PC.
